// File: rtl/rmii_tx_pkg.sv
// Shared definitions for the RMII transmitter: FSM states, preamble/SFD constants
// and the CRC-32 dibit step.
package rmii_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_BODY     = 3'd2,
        S_FCS      = 3'd3,
        S_DRAIN    = 3'd4,
        S_IFG      = 3'd5
    } state_e;

    localparam int unsigned PREAMBLE_DIBITS = 32;
    localparam logic [7:0]  SFD             = 8'hD5;
    localparam logic [1:0]  PREAMBLE_DIBIT  = 2'b01;
    localparam logic [1:0]  SFD_LAST_DIBIT  = SFD[7:6];
    localparam logic [31:0] CRC32_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    // Reflected CRC-32, two bits per call, d[0] is the earlier bit on the wire.
    function automatic logic [31:0] crc32_dibit_step(input logic [31:0] crc, input logic [1:0] d);
        logic [31:0] c;
        c = crc;
        for (int unsigned i = 0; i < 2; i++) begin
            c = (c >> 1) ^ (((c[0] ^ d[i]) == 1'b1) ? CRC32_POLY : '0);
        end
        return c;
    endfunction

endpackage

// File: rtl/rmii_tx_crc32.sv
// CRC-32 accumulator advancing one RMII dibit per clock; only instantiated
// when the transmitter generates the FCS itself.
module crc32_dibit
    import rmii_tx_pkg::*;
(
    input  logic        clk_i,
    input  logic        arst_n_i,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [1:0]  din_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init_i) begin
            crc_d = CRC32_INIT;
        end else if (en_i) begin
            crc_d = crc32_dibit_step(crc_q, din_i);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            crc_q <= CRC32_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/rmii_tx_gray.sv
// Binary to gray converter for the cross-domain monitor counters.
module my_bin2gray #(
    parameter int unsigned W = 16
)(
    input  logic [W-1:0] bin_i,
    output logic [W-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/rmii_tx.sv
// RMII 100 Mb/s transmitter: show-ahead FIFO octets -> preamble/SFD/body dibits.
// Define RMII_TX_FCS_EN to append a locally generated CRC-32 FCS.
module rmii_tx
    import rmii_tx_pkg::*;
#(
    parameter int unsigned IFG_CYCLES = 48,
    parameter int unsigned CNT_W      = 16
)(
    input  logic             REF_CLK,
    input  logic             arst_n,
    input  logic [7:0]       fifo_dout,
    input  logic             fifo_EOD_out,
    input  logic             fifo_empty,
    output logic             fifo_rden,
    output logic             TXD0,
    output logic             TXD1,
    output logic             TX_EN,
    output logic [CNT_W-1:0] succ_tx_count_gray,
    output logic [CNT_W-1:0] underrun_count_gray
);

    localparam int unsigned TMR_MAX = (IFG_CYCLES > PREAMBLE_DIBITS) ? IFG_CYCLES : PREAMBLE_DIBITS;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] PRE_LAST = TMR_W'(PREAMBLE_DIBITS - 1);
    localparam logic [TMR_W-1:0] IFG_LAST = TMR_W'(IFG_CYCLES - 1);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic [1:0]       txd_q, txd_d;
    logic             tx_en_q, tx_en_d;
    logic [CNT_W-1:0] succ_q, succ_d;
    logic [CNT_W-1:0] under_q, under_d;

`ifdef RMII_TX_FCS_EN
    logic        crc_init;
    logic        crc_en;
    logic [31:0] crc;
    logic [31:0] fcs;

    crc32_dibit u_crc (
        .clk_i    (REF_CLK),
        .arst_n_i (arst_n),
        .init_i   (crc_init),
        .en_i     (crc_en),
        .din_i    (txd_d),
        .crc_o    (crc)
    );

    assign fcs = ~crc;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        txd_d     = 2'b00;
        tx_en_d   = 1'b0;
        fifo_rden = 1'b0;
        succ_d    = succ_q;
        under_d   = under_q;
`ifdef RMII_TX_FCS_EN
        crc_init  = 1'b0;
        crc_en    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_PREAMBLE;
                    cnt_d   = '0;
                end
            end
            S_PREAMBLE: begin
                tx_en_d = 1'b1;
                txd_d   = (cnt_q == PRE_LAST) ? SFD_LAST_DIBIT : PREAMBLE_DIBIT;
                cnt_d   = cnt_q + 1'b1;
`ifdef RMII_TX_FCS_EN
                crc_init = 1'b1;
`endif
                if (cnt_q == PRE_LAST) begin
                    state_d = S_BODY;
                    cnt_d   = '0;
                end
            end
            S_BODY: begin
                // Head vanished mid-frame (or never arrived for the next octet): abort.
                if (fifo_empty) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                    under_d = under_q + 1'b1;
                end else begin
                    tx_en_d = 1'b1;
                    txd_d   = fifo_dout[{cnt_q[1:0], 1'b0} +: 2];
                    cnt_d   = cnt_q + 1'b1;
`ifdef RMII_TX_FCS_EN
                    crc_en  = 1'b1;
`endif
                    if (cnt_q[1:0] == 2'd3) begin
                        fifo_rden = 1'b1;
                        cnt_d     = '0;
                        if (fifo_EOD_out) begin
`ifdef RMII_TX_FCS_EN
                            state_d = S_FCS;
`else
                            state_d = S_IFG;
                            succ_d  = succ_q + 1'b1;
`endif
                        end
                    end
                end
            end
`ifdef RMII_TX_FCS_EN
            S_FCS: begin
                tx_en_d = 1'b1;
                txd_d   = fcs[{cnt_q[3:0], 1'b0} +: 2];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q[3:0] == 4'd15) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                    succ_d  = succ_q + 1'b1;
                end
            end
`endif
            S_DRAIN: begin
                if (!fifo_empty) begin
                    fifo_rden = 1'b1;
                    if (fifo_EOD_out) begin
                        state_d = S_IFG;
                        cnt_d   = '0;
                    end
                end
            end
            S_IFG: begin
                cnt_d = cnt_q + 1'b1;
                // Skipping S_IDLE keeps the gap at exactly IFG_CYCLES for back-to-back frames.
                if (cnt_q == IFG_LAST) begin
                    cnt_d   = '0;
                    state_d = fifo_empty ? S_IDLE : S_PREAMBLE;
                end
            end
            default: begin
                state_d = S_IFG;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            txd_q   <= 2'b00;
            tx_en_q <= 1'b0;
            succ_q  <= '0;
            under_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
            tx_en_q <= tx_en_d;
            succ_q  <= succ_d;
            under_q <= under_d;
        end
    end

    assign TXD0  = txd_q[0];
    assign TXD1  = txd_q[1];
    assign TX_EN = tx_en_q;

    my_bin2gray #(.W(CNT_W)) u_succ_gray (
        .bin_i  (succ_q),
        .gray_o (succ_tx_count_gray)
    );

    my_bin2gray #(.W(CNT_W)) u_under_gray (
        .bin_i  (under_q),
        .gray_o (underrun_count_gray)
    );

endmodule

// File: tb/tb_rmii_tx.sv
// Scoreboard bench for rmii_tx: stimulus queues expected frames/dibits and
// register checks; a negedge monitor pops and compares them.
module tb_rmii_tx;

    localparam int unsigned CNT_W = 4;

    logic             REF_CLK = 1'b0;
    logic             arst_n;
    logic [7:0]       fifo_dout;
    logic             fifo_EOD_out;
    logic             fifo_empty;
    logic             fifo_rden;
    logic             TXD0;
    logic             TXD1;
    logic             TX_EN;
    logic [CNT_W-1:0] succ_tx_count_gray;
    logic [CNT_W-1:0] underrun_count_gray;

    always #10 REF_CLK = ~REF_CLK;

    rmii_tx #(.IFG_CYCLES(48), .CNT_W(CNT_W)) dut (
        .REF_CLK             (REF_CLK),
        .arst_n              (arst_n),
        .fifo_dout           (fifo_dout),
        .fifo_EOD_out        (fifo_EOD_out),
        .fifo_empty          (fifo_empty),
        .fifo_rden           (fifo_rden),
        .TXD0                (TXD0),
        .TXD1                (TXD1),
        .TX_EN               (TX_EN),
        .succ_tx_count_gray  (succ_tx_count_gray),
        .underrun_count_gray (underrun_count_gray)
    );

    typedef struct { int len; int gap; } frame_t;
    typedef struct { int sel; int exp; int tag; } req_t;

    localparam int SEL_TXEN = 0, SEL_TXD = 1, SEL_SUCC = 2, SEL_UNDER = 3, SEL_RDEN = 4, SEL_TMO = 5;

    logic [8:0]  fq[$];
    logic [1:0]  exp_d[$];
    frame_t      exp_f[$];
    req_t        req_q[$];
    int          checks = 0;
    int          errors = 0;
    int          timeout_cnt = 0;
    bit          mon_skip = 1'b1;
    bit          done = 1'b0;
    int          tag = 0;
    logic [CNT_W-1:0] exp_succ;

    function automatic int gray(input logic [CNT_W-1:0] b);
        return int'(b ^ (b >> 1));
    endfunction

    task automatic refresh();
        fifo_empty   = (fq.size() == 0);
        fifo_dout    = fifo_empty ? 8'h00 : fq[0][7:0];
        fifo_EOD_out = fifo_empty ? 1'b0 : fq[0][8];
    endtask

    task automatic tick();
        logic       r;
        logic [8:0] tmp;
        @(negedge REF_CLK);
        r = fifo_rden;
        @(posedge REF_CLK);
        #1;
        if (r && fq.size() != 0) begin
            tmp = fq.pop_front();
        end
        refresh();
    endtask

    task automatic fifo_push(input logic [7:0] b, input logic eod);
        fq.push_back({eod, b});
        refresh();
    endtask

    task automatic q_frame(input int len, input int gap);
        exp_f.push_back('{len, gap});
        for (int i = 0; i < 31; i++) exp_d.push_back(2'b01);
        exp_d.push_back(2'b11);
    endtask

    task automatic exp_octet(input logic [7:0] b);
        for (int i = 0; i < 4; i++) exp_d.push_back(b[2*i +: 2]);
    endtask

    task automatic send(input logic [7:0] b, input logic eod);
        fifo_push(b, eod);
        exp_octet(b);
    endtask

    task automatic req(input int sel, input int exp);
        req_q.push_back('{sel, exp, tag});
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_f.size() != 0 || exp_d.size() != 0 || TX_EN) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            timeout_cnt++;
            req(SEL_TMO, 0);
        end
        tick();
        tick();
    endtask

    task automatic chk(input string nm, input int t, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s test%0d got %0d want %0d", nm, t, act, exp);
        end
    endtask

    // Monitor / scoreboard
    int     run_len = 0;
    int     gap_len = 0;
    int     cur_len = -1;
    logic   prev_en = 1'b0;
    always @(negedge REF_CLK) begin : mon
        frame_t     f;
        req_t       r;
        logic [1:0] e;
        if (mon_skip) begin
            run_len = 0;
            prev_en = TX_EN;
        end else begin
            if (TX_EN) begin
                if (!prev_en) begin
                    if (exp_f.size() == 0) begin
                        chk("unexpected_frame", tag, 1, 0);
                        cur_len = -1;
                    end else begin
                        f = exp_f.pop_front();
                        cur_len = f.len;
                        if (f.gap >= 0) chk("ifg_len", tag, gap_len, f.gap);
                    end
                    run_len = 0;
                end
                run_len++;
                if (exp_d.size() == 0) begin
                    chk("extra_dibit", tag, int'({TXD1, TXD0}), -1);
                end else begin
                    e = exp_d.pop_front();
                    chk("dibit", tag, int'({TXD1, TXD0}), int'(e));
                end
            end else begin
                if (prev_en) begin
                    chk("tx_en_len", tag, run_len, cur_len);
                    gap_len = 0;
                end
                gap_len++;
            end
            prev_en = TX_EN;
        end
        while (req_q.size() != 0) begin
            r = req_q.pop_front();
            case (r.sel)
                SEL_TXEN:  chk("tx_en", r.tag, int'(TX_EN), r.exp);
                SEL_TXD:   chk("txd", r.tag, int'({TXD1, TXD0}), r.exp);
                SEL_SUCC:  chk("succ_gray", r.tag, int'(succ_tx_count_gray), r.exp);
                SEL_UNDER: chk("underrun_gray", r.tag, int'(underrun_count_gray), r.exp);
                SEL_RDEN:  chk("fifo_rden", r.tag, int'(fifo_rden), r.exp);
                default:   chk("timeout", r.tag, timeout_cnt, r.exp);
            endcase
        end
        if (done) begin
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n   = 1'b0;
        exp_succ = '0;
        refresh();
        // reset state
        req(SEL_TXEN, 0);
        req(SEL_TXD, 0);
        req(SEL_RDEN, 0);
        req(SEL_SUCC, 0);
        req(SEL_UNDER, 0);
        tick();
        tick();
        arst_n   = 1'b1;
        tick();
        mon_skip = 1'b0;

        // 1: two-octet frame, no gap expectation
        tag = 1;
        q_frame(40, -1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b1);
        wait_done(500);
        exp_succ++;
        req(SEL_SUCC, gray(exp_succ));

        // 2: "123456789", FCS 26 39 F4 CB either generated or supplied
        tag = 2;
        q_frame(84, -1);
`ifdef RMII_TX_FCS_EN
        for (int i = 0; i < 9; i++) send(8'h31 + 8'(i), (i == 8));
        exp_octet(8'h26);
        exp_octet(8'h39);
        exp_octet(8'hF4);
        exp_octet(8'hCB);
`else
        for (int i = 0; i < 9; i++) send(8'h31 + 8'(i), 1'b0);
        send(8'h26, 1'b0);
        send(8'h39, 1'b0);
        send(8'hF4, 1'b0);
        send(8'hCB, 1'b1);
`endif
        wait_done(800);
        exp_succ++;
        req(SEL_SUCC, gray(exp_succ));

        // 3: back-to-back frames, exact 48-cycle gap
        tag = 3;
        q_frame(40, -1);
        send(8'h10, 1'b0);
        send(8'h20, 1'b1);
        q_frame(36, 48);
        send(8'h30, 1'b1);
        wait_done(800);
        exp_succ = exp_succ + 2;
        req(SEL_SUCC, gray(exp_succ));
        req(SEL_UNDER, 0);

        // 4: underrun after 3rd octet, remainder drained, next frame normal
        tag = 4;
        q_frame(44, -1);
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        wait_done(500);
        req(SEL_UNDER, 1);
        req(SEL_SUCC, gray(exp_succ));
        tick();
        fifo_push(8'hD1, 1'b0);
        fifo_push(8'hD2, 1'b1);
        q_frame(36, -1);
        send(8'hE1, 1'b1);
        wait_done(800);
        exp_succ++;
        req(SEL_SUCC, gray(exp_succ));
        req(SEL_UNDER, 1);

        // 5: run the good-frame counter to all-ones, then wrap
        tag = 5;
        while (exp_succ != '1) begin
            q_frame(36, -1);
            send(8'h5A, 1'b1);
            wait_done(500);
            exp_succ++;
        end
        req(SEL_SUCC, gray(exp_succ));
        q_frame(36, -1);
        send(8'hA5, 1'b1);
        wait_done(500);
        req(SEL_SUCC, 0);

        // 6: async reset mid-body; remainder becomes a new frame
        tag = 6;
        mon_skip = 1'b1;
        fifo_push(8'h11, 1'b0);
        fifo_push(8'h22, 1'b0);
        fifo_push(8'h33, 1'b0);
        fifo_push(8'h44, 1'b1);
        begin
            int n;
            n = 0;
            while (!TX_EN && n < 100) begin
                tick();
                n++;
            end
            if (n >= 100) begin
                timeout_cnt++;
                req(SEL_TMO, 0);
            end
        end
        repeat (41) tick();
        arst_n = 1'b0;
        req(SEL_TXEN, 0);
        req(SEL_TXD, 0);
        req(SEL_SUCC, 0);
        req(SEL_UNDER, 0);
        tick();
        tick();
        q_frame(40, -1);
        exp_octet(8'h33);
        exp_octet(8'h44);
        arst_n   = 1'b1;
        mon_skip = 1'b0;
        wait_done(500);
        req(SEL_SUCC, 1);
        req(SEL_UNDER, 0);

        tick();
        tick();
        done = 1'b1;
    end

endmodule
